gray_counter: RTL

//  Parametrised up/down counter that holds its state in Gray code and registers both Gray and binary views.

---
 rtl/gray_pkg.sv | 27 ++
 rtl/gray_decode.sv | 18 +
 rtl/gray_counter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers and counter operation encoding
package gray_pkg;

  typedef enum logic [2:0] {
    CNT_HOLD,
    CNT_UP,
    CNT_DOWN,
    CNT_LOAD,
    CNT_CLEAR
  } cnt_op_t;

  // Binary to Gray; caller masks the result to its own width.
  function automatic logic [31:0] gray_encode(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary by prefix XOR from the MSB down; unused upper bits must be zero.
  function automatic logic [31:0] gray_decode(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_decode.sv
// rtl/gray_decode.sv - combinational prefix-XOR Gray to binary decoder
module gray_decode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down Gray-state counter with load, clear and wrap flag; optional GRAY_COUNTER_CHECK_EN
module gray_counter
  import gray_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] gray_q,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_next,
  output logic             wrap
`ifdef GRAY_COUNTER_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(gray_encode(32'(RST_BIN)));
  localparam logic [WIDTH-1:0] MAX_BIN  = '1;

  cnt_op_t          op;
  logic [WIDTH-1:0] load_dec;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_next;
  logic             wrap_next;

  gray_decode #(.WIDTH(WIDTH)) u_load_dec (
    .gray (load_val),
    .bin  (load_dec)
  );

  // Pick the operation by priority; reset is folded in so gray_next is exact for lookahead.
  always_comb begin
    op = CNT_HOLD;
    if (!reset_n || clear) begin
      op = CNT_CLEAR;
    end else if (load) begin
      op = CNT_LOAD;
    end else if (inc && !dec) begin
      op = CNT_UP;
    end else if (dec && !inc) begin
      op = CNT_DOWN;
    end
  end

  // Next binary value, its Gray image, and whether this step crosses the MAX/0 boundary.
  always_comb begin
    load_bin  = load_gray ? load_dec : load_val;
    bin_next  = bin_q;
    wrap_next = 1'b0;
    case (op)
      CNT_CLEAR: bin_next = RST_BIN;
      CNT_LOAD:  bin_next = load_bin;
      CNT_UP: begin
        bin_next  = bin_q + WIDTH'(1);
        wrap_next = (bin_q == MAX_BIN);
      end
      CNT_DOWN: begin
        bin_next  = bin_q - WIDTH'(1);
        wrap_next = (bin_q == '0);
      end
      default:   bin_next = bin_q;
    endcase
    gray_next = WIDTH'(gray_encode(32'(bin_next)));
  end

  // Counter state: both views registered together so bin_q always matches gray_q.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      wrap   <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      wrap   <= wrap_next;
    end
  end

`ifdef GRAY_COUNTER_CHECK_EN
  logic [WIDTH-1:0] chk_bin;
  logic [WIDTH-1:0] gray_prev_q;
  logic             counted_q;
  logic             step_bad;
  logic             cons_bad;

  gray_decode #(.WIDTH(WIDTH)) u_chk_dec (
    .gray (gray_q),
    .bin  (chk_bin)
  );

  // A count step must flip exactly one Gray bit, and the binary view must match the Gray state.
  always_comb begin
    step_bad = counted_q && ($countones(gray_q ^ gray_prev_q) != 1);
    cons_bad = (chk_bin != bin_q);
  end

  // Remember the previous state and whether it was left by a count step; err is sticky until reset_n.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gray_prev_q <= RST_GRAY;
      counted_q   <= 1'b0;
      err         <= 1'b0;
    end else begin
      gray_prev_q <= gray_q;
      counted_q   <= (op == CNT_UP) || (op == CNT_DOWN);
      err         <= err | step_bad | cons_bad;
    end
  end

  a_gray_ok : assert property (@(posedge clk) disable iff (!reset_n) !(step_bad || cons_bad));
`endif

endmodule
